// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and instruction fetch handshake for a single-issue front end.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap redirects whose target has bit 1 set.
module pc_fetch_unit #(
    parameter int               NBits    = 32,
    parameter logic [NBits-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid_i,
    input  logic [NBits-1:0] redirect_target_i,
    input  logic             stall_i,
    input  logic             imem_ready_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             imem_req_o,
    output logic [NBits-1:0] imem_addr_o,
    output logic             inst_valid_o,
    output logic [31:0]      inst_o,
    output logic [NBits-1:0] pc_o,
    output logic [NBits-1:0] pc_plus4_o,
    output logic             misalign_o
);
    typedef enum logic [1:0] {BOOT, REQ, HOLD, FAULT} state_t;
    state_t           state_q, state_d;
    logic [NBits-1:0] pc_q, pc_d, pco_q, pco_d, tgt;
    logic [31:0]      inst_q, inst_d;
    logic             mis_q, mis_d, bad;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt = redirect_target_i & ~{{(NBits-1){1'b0}}, 1'b1};
    assign bad = redirect_target_i[1];
`else
    assign tgt = redirect_target_i & ~{{(NBits-2){1'b0}}, 2'b11};
    assign bad = 1'b0;
`endif
    assign imem_req_o   = state_q == REQ;
    assign inst_valid_o = state_q == HOLD;
    assign imem_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign pc_o         = pco_q;
    assign pc_plus4_o   = pco_q + NBits'(4);
    assign misalign_o   = mis_q;
    // next-state: redirect beats memory response and stall; BOOT and FAULT ignore redirects
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pco_d   = pco_q;
        inst_d  = inst_q;
        mis_d   = mis_q;
        case (state_q)
            BOOT: state_d = REQ;
            REQ, HOLD: begin
                if (redirect_valid_i) begin
                    if (bad) begin
                        state_d = FAULT;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        pc_d    = tgt;
                    end
                end else if (state_q == REQ && imem_ready_i) begin
                    state_d = HOLD;
                    inst_d  = imem_rdata_i;
                    pco_d   = pc_q;
                    pc_d    = pc_q + NBits'(4);
                end else if (state_q == HOLD && !stall_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = FAULT;
        endcase
    end
    // state register with synchronous reset dominating all inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pco_q   <= '0;
            inst_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pco_q   <= pco_d;
            inst_q  <= inst_d;
            mis_q   <= mis_d;
        end
    end
endmodule
